// File: rtl/cpu_bus_dma_pkg.sv
// rtl/cpu_bus_dma_pkg.sv - shared region codes, DMA states and address map for the CPU bus
package cpu_bus_dma_pkg;

  localparam logic [15:0] PPU_BASE   = 16'h2000;
  localparam logic [15:0] IO_BASE    = 16'h4000;
  localparam logic [15:0] DMA_ADDR   = 16'h4014;
  localparam logic [15:0] UNMAP_BASE = 16'h4020;
  localparam logic [15:0] PRG_BASE   = 16'h8000;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_RAM,
    REG_PPU,
    REG_IO,
    REG_ROM
  } region_e;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_DUMMY,
    DMA_ALIGN,
    DMA_READ,
    DMA_WRITE,
    DMA_DONE
  } dma_state_e;

  // $4014 decodes to nothing so it is never forwarded to the IO block.
  function automatic region_e decode_region(input logic [15:0] addr);
    region_e r;
    if (addr < PPU_BASE)        r = REG_RAM;
    else if (addr < IO_BASE)    r = REG_PPU;
    else if (addr == DMA_ADDR)  r = REG_NONE;
    else if (addr < UNMAP_BASE) r = REG_IO;
    else if (addr < PRG_BASE)   r = REG_NONE;
    else                        r = REG_ROM;
    return r;
  endfunction

endpackage

// File: rtl/cpu_bus_dma_ram.sv
// rtl/cpu_bus_dma_ram.sv - work RAM, synchronous read-before-write
module cpu_ram #(
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i
);

  logic [7:0] mem_q [0:(1<<AW)-1];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_bus_dma.sv
// rtl/cpu_bus_dma.sv - NES CPU bus decoder, read mux and OAM DMA engine
module cpu_bus_dma
  import cpu_bus_dma_pkg::*;
#(
  parameter int         RAM_AW  = 11,
  parameter int         PRG_AW  = 15,
  parameter logic [2:0] OAM_REG = 3'd4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [15:0]       cpu_raddr_i,
  output logic [7:0]        cpu_rdata_o,
  input  logic              cpu_wen_i,
  input  logic [15:0]       cpu_waddr_i,
  input  logic [7:0]        cpu_wdata_i,
  output logic              cpu_rdy_o,
  output logic [2:0]        ppu_reg_o,
  output logic              ppu_re_o,
  output logic              ppu_we_o,
  output logic [7:0]        ppu_wdata_o,
  input  logic [7:0]        ppu_rdata_i,
  output logic [4:0]        io_addr_o,
  output logic              io_re_o,
  output logic              io_we_o,
  output logic [7:0]        io_wdata_o,
  input  logic [7:0]        io_rdata_i,
  output logic [PRG_AW-1:0] prg_addr_o,
  input  logic [7:0]        prg_rdata_i
);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic       cpu_rdy_q, cpu_rdy_d;
  logic       align_q, align_d;
  logic       parity_q;
  region_e    rreg_q;
  logic [7:0] open_bus_q;

  logic [15:0] rd_addr;
  logic        rd_en, wr_en, dma_start, dma_wr;
  region_e     rd_reg, wr_reg;
  logic [7:0]  ram_rdata;

  // The DMA fetch borrows the CPU read path so its source goes through the normal decoder.
  always_comb begin
    rd_addr = cpu_raddr_i;
    rd_en   = 1'b0;
    if (state_q == DMA_READ) begin
      rd_addr = {page_q, idx_q};
      rd_en   = 1'b1;
    end else if (cpu_rdy_q) begin
      rd_en = 1'b1;
    end
    wr_en     = cpu_rdy_q && cpu_wen_i;
    rd_reg    = rd_en ? decode_region(rd_addr) : REG_NONE;
    wr_reg    = wr_en ? decode_region(cpu_waddr_i) : REG_NONE;
    dma_start = (state_q == DMA_IDLE) && wr_en && (cpu_waddr_i == DMA_ADDR);
    dma_wr    = (state_q == DMA_WRITE);
  end

  cpu_ram #(.AW(RAM_AW)) u_ram (
    .clk_i   (clk_i),
    .raddr_i (rd_addr[RAM_AW-1:0]),
    .rdata_o (ram_rdata),
    .we_i    (wr_reg == REG_RAM),
    .waddr_i (cpu_waddr_i[RAM_AW-1:0]),
    .wdata_i (cpu_wdata_i)
  );

  always_comb begin
    case (rreg_q)
      REG_RAM: cpu_rdata_o = ram_rdata;
      REG_PPU: cpu_rdata_o = ppu_rdata_i;
      REG_IO:  cpu_rdata_o = io_rdata_i;
      REG_ROM: cpu_rdata_o = prg_rdata_i;
      default: cpu_rdata_o = open_bus_q;
    endcase
  end

  assign cpu_rdy_o   = cpu_rdy_q;
  assign ppu_re_o    = (rd_reg == REG_PPU);
  assign ppu_we_o    = dma_wr || (wr_reg == REG_PPU);
  assign ppu_reg_o   = dma_wr ? OAM_REG :
                       (wr_reg == REG_PPU) ? cpu_waddr_i[2:0] : rd_addr[2:0];
  assign ppu_wdata_o = dma_wr ? cpu_rdata_o : cpu_wdata_i;
  assign io_re_o     = (rd_reg == REG_IO);
  assign io_we_o     = (wr_reg == REG_IO);
  assign io_addr_o   = io_we_o ? cpu_waddr_i[4:0] : rd_addr[4:0];
  assign io_wdata_o  = cpu_wdata_i;
  assign prg_addr_o  = rd_addr[PRG_AW-1:0];

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    cpu_rdy_d = cpu_rdy_q;
    align_d   = align_q;
    case (state_q)
      DMA_IDLE: begin
        if (dma_start) begin
          page_d    = cpu_wdata_i;
          idx_d     = 8'd0;
          cpu_rdy_d = 1'b0;
          align_d   = parity_q;
          state_d   = DMA_DUMMY;
        end
      end
      DMA_DUMMY: state_d = align_q ? DMA_ALIGN : DMA_READ;
      DMA_ALIGN: state_d = DMA_READ;
      DMA_READ:  state_d = DMA_WRITE;
      DMA_WRITE: begin
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'hFF) begin
          state_d   = DMA_DONE;
          cpu_rdy_d = 1'b1;
        end else begin
          state_d = DMA_READ;
        end
      end
      DMA_DONE:  state_d = DMA_IDLE;
      default:   state_d = DMA_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= DMA_IDLE;
      page_q     <= 8'd0;
      idx_q      <= 8'd0;
      cpu_rdy_q  <= 1'b1;
      align_q    <= 1'b0;
      parity_q   <= 1'b0;
      rreg_q     <= REG_NONE;
      open_bus_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      idx_q      <= idx_d;
      cpu_rdy_q  <= cpu_rdy_d;
      align_q    <= align_d;
      parity_q   <= ~parity_q;
      rreg_q     <= rd_reg;
      open_bus_q <= cpu_rdata_o;
    end
  end

endmodule

// File: tb/tb_cpu_bus_dma.sv
// tb/tb_cpu_bus_dma.sv - randomized bench for cpu_bus_dma against a cycle-schedule reference model
module tb_cpu_bus_dma;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] cpu_raddr_i = 16'h5000;
  logic        cpu_wen_i = 1'b0;
  logic [15:0] cpu_waddr_i = 16'h0000;
  logic [7:0]  cpu_wdata_i = 8'h00;
  logic [7:0]  cpu_rdata_o;
  logic        cpu_rdy_o;
  logic [2:0]  ppu_reg_o;
  logic        ppu_re_o, ppu_we_o;
  logic [7:0]  ppu_wdata_o;
  logic [7:0]  ppu_rdata_i = 8'h00;
  logic [4:0]  io_addr_o;
  logic        io_re_o, io_we_o;
  logic [7:0]  io_wdata_o;
  logic [7:0]  io_rdata_i = 8'h00;
  logic [14:0] prg_addr_o;
  logic [7:0]  prg_rdata_i = 8'h00;

  cpu_bus_dma dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cpu_raddr_i(cpu_raddr_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_wen_i(cpu_wen_i), .cpu_waddr_i(cpu_waddr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdy_o(cpu_rdy_o),
    .ppu_reg_o(ppu_reg_o), .ppu_re_o(ppu_re_o), .ppu_we_o(ppu_we_o),
    .ppu_wdata_o(ppu_wdata_o), .ppu_rdata_i(ppu_rdata_i),
    .io_addr_o(io_addr_o), .io_re_o(io_re_o), .io_we_o(io_we_o),
    .io_wdata_o(io_wdata_o), .io_rdata_i(io_rdata_i),
    .prg_addr_o(prg_addr_o), .prg_rdata_i(prg_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:2047];
  int         cyc;
  bit         dma_on;
  int         dw, dp, dma_wr, low_cnt;
  logic [7:0] dbytes [0:255];
  bit         pend_valid;
  logic [7:0] pend_val, last_cur;
  logic [7:0] oam_log [$];
  logic [7:0] obs_rdata;
  logic       obs_rdy, obs_ppu_we;
  logic [2:0] obs_ppu_reg;

  // External device models: each returns a fixed function of the address it was given.
  function automatic logic [7:0] rom_f(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hC3;
  endfunction
  function automatic logic [7:0] ppu_f(input logic [2:0] r);
    return 8'h90 + {5'd0, r};
  endfunction
  function automatic logic [7:0] io_f(input logic [4:0] a);
    return {3'b011, a};
  endfunction

  // 0 none, 1 RAM, 2 PPU, 3 IO, 4 ROM
  function automatic int region(input logic [15:0] a);
    if (a <= 16'h1FFF) return 1;
    if (a <= 16'h3FFF) return 2;
    if (a <= 16'h401F) return (a == 16'h4014) ? 0 : 3;
    if (a <= 16'h7FFF) return 0;
    return 4;
  endfunction

  function automatic logic [15:0] rand_addr();
    int r;
    logic [15:0] a;
    r = $urandom_range(0, 9);
    if (r <= 3)      a = 16'($urandom_range(0, 16'h1FFF));
    else if (r == 4) a = 16'($urandom_range(16'h2000, 16'h3FFF));
    else if (r == 5) begin
      a = 16'($urandom_range(16'h4000, 16'h401F));
      if (a == 16'h4014) a = 16'h4015;
    end
    else if (r == 6) a = 16'($urandom_range(16'h4020, 16'h7FFF));
    else             a = 16'($urandom_range(16'h8000, 16'hFFFF));
    return a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycle(input bit rst, input logic [15:0] ra, input bit we,
                       input logic [15:0] wa, input logic [7:0] wd);
    bit rdy_e, is_dw, start;
    int k, off, rr, wr;
    logic [7:0] cur, np, npp, nio;
    logic [15:0] src;
    reset_i = rst; cpu_raddr_i = ra; cpu_wen_i = we; cpu_waddr_i = wa; cpu_wdata_i = wd;
    #1;
    obs_rdata = cpu_rdata_o; obs_rdy = cpu_rdy_o;
    obs_ppu_we = ppu_we_o; obs_ppu_reg = ppu_reg_o;
    if (!cpu_rdy_o) low_cnt++;
    if (ppu_we_o && ppu_reg_o == 3'd4) oam_log.push_back(ppu_wdata_o);
    if (!rst) begin
      if (dma_on && cyc > dw + 514 + dp) dma_on = 0;
      rdy_e = !(dma_on && cyc >= dw + 1 && cyc <= dw + 513 + dp);
      off   = cyc - dw - 3 - dp;
      is_dw = dma_on && off >= 0 && off <= 510 && (off % 2 == 0);
      k     = is_dw ? off / 2 : 0;
      rr    = rdy_e ? region(ra) : 0;
      wr    = (rdy_e && we) ? region(wa) : 0;
      start = rdy_e && we && wa == 16'h4014 && !dma_on;
      chk("cpu_rdy", cpu_rdy_o, rdy_e);
      if (pend_valid) chk("cpu_rdata", cpu_rdata_o, pend_val);
      chk("ppu_we", ppu_we_o, is_dw || wr == 2);
      if (is_dw) begin
        chk("oam_reg", ppu_reg_o, 3'd4);
        chk("oam_data", ppu_wdata_o, dbytes[k]);
        dma_wr++;
      end else if (wr == 2) begin
        chk("ppu_wreg", ppu_reg_o, wa[2:0]);
        chk("ppu_wdata", ppu_wdata_o, wd);
      end
      chk("ppu_re", ppu_re_o, rr == 2);
      if (rr == 2 && !ppu_we_o) chk("ppu_rreg", ppu_reg_o, ra[2:0]);
      chk("io_we", io_we_o, wr == 3);
      if (wr == 3) begin
        chk("io_waddr", io_addr_o, wa[4:0]);
        chk("io_wdata", io_wdata_o, wd);
      end
      chk("io_re", io_re_o, rr == 3);
      if (rr == 3 && wr != 3) chk("io_raddr", io_addr_o, ra[4:0]);
      if (rr == 4) chk("prg_addr", prg_addr_o, ra[14:0]);
      cur = pend_valid ? pend_val : (is_dw ? dbytes[k] : last_cur);
      pend_valid = rdy_e;
      case (rr)
        1:       pend_val = mem[ra[10:0]];
        2:       pend_val = ppu_f(ra[2:0]);
        3:       pend_val = io_f(ra[4:0]);
        4:       pend_val = rom_f(ra[14:0]);
        default: pend_val = cur;
      endcase
      last_cur = cur;
      if (wr == 1) mem[wa[10:0]] = wd;
      if (start) begin
        dma_on = 1; dw = cyc; dp = cyc % 2; dma_wr = 0;
        for (int j = 0; j < 256; j++) begin
          src = {wd, 8'(j)};
          dbytes[j] = (region(src) == 1) ? mem[src[10:0]] : rom_f(src[14:0]);
        end
      end
    end
    np  = rom_f(prg_addr_o);
    npp = ppu_re_o ? ppu_f(ppu_reg_o) : 8'h00;
    nio = io_re_o ? io_f(io_addr_o) : 8'h00;
    @(posedge clk_i);
    if (rst) begin
      cyc = 0; dma_on = 0; pend_valid = 1; pend_val = 8'h00; last_cur = 8'h00;
    end else begin
      cyc++;
    end
    #1;
    prg_rdata_i = np; ppu_rdata_i = npp; io_rdata_i = nio;
    @(negedge clk_i);
  endtask

  task automatic idle();
    cycle(0, 16'h5000, 0, 16'h0000, 8'h00);
  endtask

  // Runs until the model's DMA has finished; CPU traffic (incl. $4014) is thrown at the stalled bus.
  task automatic run_dma();
    int guard;
    bit in_dma, we;
    logic [15:0] wa;
    guard = 0;
    while (dma_on && guard < 800) begin
      in_dma = dma_on && cyc <= dw + 514 + dp;
      we = in_dma && ($urandom_range(0, 1) == 1);
      wa = ($urandom_range(0, 3) == 0) ? 16'h4014 : rand_addr();
      cycle(0, rand_addr(), we, wa, 8'($urandom));
      guard++;
    end
    if (dma_on) begin
      checks++; errors++;
      $display("FAIL dma_timeout actual=busy required=done");
    end
  endtask

  task automatic chk_order();
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (k >= oam_log.size() || oam_log[k] !== 8'(k)) bad++;
    chk("oam_order_bad", bad, 0);
  endtask

  initial begin
    bit we;
    logic [15:0] ra, wa;
    logic [7:0] wd;
    @(negedge clk_i);
    cycle(1, 16'h5000, 0, 16'h0000, 8'h00);
    cycle(1, 16'h5000, 0, 16'h0000, 8'h00);
    idle();
    chk("reset_rdata", obs_rdata, 8'h00);
    chk("reset_rdy", obs_rdy, 1'b1);
    chk("reset_ppu_we", obs_ppu_we, 1'b0);

    for (int i = 0; i < 2048; i++) cycle(0, 16'h5000, 1, 16'(i), 8'($urandom));

    cycle(0, 16'h5000, 1, 16'h07FF, 8'h5A);
    cycle(0, 16'h1FFF, 0, 16'h0000, 8'h00);
    idle(); chk("mirror_1fff", obs_rdata, 8'h5A);
    cycle(0, 16'h5000, 1, 16'h0000, 8'h11);
    cycle(0, 16'h0800, 0, 16'h0000, 8'h00);
    idle(); chk("mirror_0800", obs_rdata, 8'h11);
    cycle(0, 16'h5000, 1, 16'h0123, 8'h33);
    cycle(0, 16'h0123, 1, 16'h0123, 8'hAA);
    cycle(0, 16'h0123, 0, 16'h0000, 8'h00); chk("rbw_old", obs_rdata, 8'h33);
    idle(); chk("rbw_new", obs_rdata, 8'hAA);

    cycle(0, 16'h8000, 0, 16'h0000, 8'h00);
    cycle(0, 16'h4100, 0, 16'h0000, 8'h00); chk("prg_c3", obs_rdata, 8'hC3);
    cycle(0, 16'h4100, 0, 16'h0000, 8'h00); chk("open_bus_1", obs_rdata, 8'hC3);
    idle(); chk("open_bus_2", obs_rdata, 8'hC3);

    cycle(0, 16'h8000, 1, 16'h8000, 8'hFF); chk("rom_wr_no_ppu_we", obs_ppu_we, 1'b0);
    cycle(0, 16'h5000, 1, 16'h2006, 8'h77);
    chk("rom_rd", obs_rdata, 8'hC3);
    chk("ppu2006_we", obs_ppu_we, 1'b1);
    chk("ppu2006_reg", obs_ppu_reg, 3'd6);

    for (int i = 0; i < 256; i++) cycle(0, 16'h5000, 1, 16'h0200 + 16'(i), 8'(i));
    if (cyc % 2 == 1) idle();
    low_cnt = 0; oam_log.delete();
    cycle(0, 16'h5000, 1, 16'h4014, 8'h02);
    run_dma();
    chk("stall_even", low_cnt, 513);
    chk("oam_count_even", oam_log.size(), 256);
    chk_order();

    if (cyc % 2 == 0) idle();
    low_cnt = 0; oam_log.delete();
    cycle(0, 16'h5000, 1, 16'h4014, 8'h02);
    run_dma();
    chk("stall_odd", low_cnt, 514);
    chk("oam_count_odd", oam_log.size(), 256);
    chk_order();

    cycle(0, 16'h5000, 1, 16'h4014, 8'h02);
    for (int g = 0; g < 400 && dma_wr < 100; g++) idle();
    chk("abort_at_100", dma_wr, 100);
    cycle(1, 16'h5000, 0, 16'h0000, 8'h00);
    cycle(0, 16'h5000, 1, 16'h4014, 8'h02);
    chk("abort_rdy", obs_rdy, 1'b1);
    chk("abort_no_we", obs_ppu_we, 1'b0);
    chk("abort_rdata", obs_rdata, 8'h00);
    idle(); chk("restart_from_idle", obs_rdy, 1'b0);
    run_dma();

    for (int n = 0; n < 4000; n++) begin
      ra = rand_addr();
      wa = rand_addr();
      wd = 8'($urandom);
      we = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 250) == 0) begin
        we = 1; wa = 16'h4014;
        wd = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 8'h1F))
                                          : 8'($urandom_range(8'h80, 8'hFF));
      end
      if (we && region(wa) == region(ra) && (region(ra) == 2 || region(ra) == 3))
        wa = {5'd0, wa[10:0]};
      cycle(0, ra, we, wa, wd);
    end
    run_dma();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
